fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Parametrised instruction buffer between instruction fetch and `decode_stage64` in the out-of-order core. It replaces the single-entry fetch/decode handshake with a DEPTH-entry circular FIFO that carries instruction, PC and NLP BTB-hit bit. It adds pipeline flush, occupancy reporting and an optional zero-latency bypass. Fetch keeps streaming while decode/issue stalls for up to DEPTH instructions.

## Interface
- XLEN, 64, PC width
- DEPTH, 4, number of entries; power of two, ≥2
- INSTR_WIDTH, 32, instruction word width
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all entries (branch mispredict/redirect)
- fetch_response_valid_i  in  1  fetch entry valid
- fetch_response_ready_o  out  1  queue can accept an entry this cycle
- fetch_response_instruction_i  in  INSTR_WIDTH  instruction word
- fetch_response_PC_i  in  XLEN  instruction PC
- fetch_NLP_BTB_hit_i  in  1  next-line-predictor BTB hit for this entry
- decode_valid_o  out  1  head entry valid
- decode_ready_i  in  1  decode stage consumes head this cycle
- decode_instruction_o  out  INSTR_WIDTH  head instruction
- decode_PC_o  out  XLEN  head PC
- decode_NLP_BTB_hit_o  out  1  head BTB-hit bit
- occupancy_o  out  $clog2(DEPTH)+1  entries currently stored

## Operation
- Storage: DEPTH entries of {BTB hit, PC, instruction}. Read/write pointers are $clog2(DEPTH)+1 bits, the extra MSB being the wrap bit.
- Empty: pointers equal. Full: index bits equal and wrap bits differ.
- Push = fetch_response_valid_i & fetch_response_ready_o & !flush_i; writes at wr_ptr, wr_ptr+1.
- Pop = decode_valid_o & decode_ready_i & !flush_i; rd_ptr+1.
- Pointers wrap modulo 2·DEPTH naturally; no special case at the last index.
- fetch_response_ready_o = !full & !flush_i & !reset. It does not depend on decode_ready_i: no push when full, even with a same-cycle pop.
- Push and pop in the same cycle when neither empty nor full: occupancy unchanged, both pointers advance.
- decode_valid_o = !empty & !flush_i.
- When decode_valid_o=0, data outputs are forced: instruction = NOP 32'h00000013, PC = 0, BTB hit = 0.
- occupancy_o = wr_ptr − rd_ptr (modulo 2·DEPTH), registered-state-derived, range 0..DEPTH.
- Flush: on the edge where flush_i=1, both pointers reset to 0. A concurrent push or pop is ignored. Valid and ready are 0 in the flush cycle.
- Reset mid-operation: pointers clear immediately (asynchronously); contents are discarded.
- Reset values: decode_valid_o=0, fetch_response_ready_o=0 while reset is high and 1 on the first cycle after, occupancy_o=0, data outputs NOP/0/0.

## Timing
- Without bypass, latency from fetch accept to decode_valid_o is 1 cycle (entry visible the cycle after the push edge).
- Throughput is 1 entry/cycle sustained in both directions.
- Consumer stall: the head entry and its outputs stay stable while decode_valid_o=1 & decode_ready_i=0.
- Producer: holding fetch_response_valid_i while ready=0 loses nothing; the entry is taken on the first cycle ready=1.

## Configuration
- Macro: FETCH_DECODE_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, fetch_response_valid_i=1, decode_ready_i=1 and flush_i=0, the input is presented combinationally on the decode outputs with decode_valid_o=1.
  - It is consumed in the same cycle and not written to storage; occupancy is unchanged and latency is 0.
  - If decode_ready_i=0 in that case, the entry is written normally and decode_valid_o is driven from the input in that same cycle.
  - Fall-through (bypass) outputs are never registered.
- Undefined: no combinational path from fetch inputs to decode outputs; 1-cycle latency always.

## Structure
- Shared package `fetch_decode_pkg`:
  - NOP_INSTRUCTION constant (32'h00000013)
  - entry field offsets/width (INSTR_WIDTH+XLEN+1)
  - pointer-width function
- One sub-module, `fetch_decode_queue_mem`: DEPTH×entry storage array, single write port, asynchronous read at rd index, no reset on contents. Pointers, flags and bypass mux stay in the top level.

## Test plan
- Reset then single push of 32'h00000013, PC 0, decode_ready_i=1:
  - without bypass: decode_valid_o=1 one cycle later with instruction 32'h00000013, PC 0;
  - with bypass: same cycle, occupancy_o stays 0.
- decode_ready_i=0, push DEPTH=4 entries with PCs 0,4,8,12 → occupancy_o=4, fetch_response_ready_o=0. A fifth valid push is held. Raising decode_ready_i drains PCs 0,4,8,12 in order, then the held fifth entry.
- Sustained push+pop for 3·DEPTH cycles with incrementing PCs → every PC delivered exactly once, in order, across pointer wrap; occupancy_o constant.
- Queue holding 3 entries, flush_i=1 for one cycle with concurrent push → next cycle occupancy_o=0, decode_valid_o=0. The concurrent push is dropped; the next push appears as the sole head.
- Assert reset mid-stream with 2 entries stored → decode_valid_o drops to 0 without waiting for a clock edge, occupancy_o=0. After release the first new push is delivered with fetch_NLP_BTB_hit_i preserved as 1.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode instruction queue: NOP encoding,
// entry layout {BTB hit, PC, instruction} and pointer sizing.
package fetch_decode_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  // Index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned entry_width(input int unsigned instr_w,
                                              input int unsigned xlen);
    return instr_w + xlen + 1;
  endfunction

  // Instruction occupies [instr_w-1:0], PC sits directly above it.
  function automatic int unsigned pc_lsb(input int unsigned instr_w);
    return instr_w;
  endfunction

  // BTB-hit flag is the entry MSB.
  function automatic int unsigned hit_bit(input int unsigned instr_w,
                                          input int unsigned xlen);
    return instr_w + xlen;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage for fetch_decode_queue: single write port, asynchronous
// read, contents not reset (validity is tracked by the pointers).
module fetch_decode_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 97,
  parameter int unsigned AW    = 2
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the accepted fetch entry at the write index.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Head entry is read combinationally.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry circular instruction buffer between fetch and decode with
// flush and occupancy reporting.
// Optional zero-latency fall-through: define FETCH_DECODE_QUEUE_BYPASS_EN.
module fetch_decode_queue
  import fetch_decode_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     fetch_response_valid_i,
  output logic                     fetch_response_ready_o,
  input  logic [INSTR_WIDTH-1:0]   fetch_response_instruction_i,
  input  logic [XLEN-1:0]          fetch_response_PC_i,
  input  logic                     fetch_NLP_BTB_hit_i,
  output logic                     decode_valid_o,
  input  logic                     decode_ready_i,
  output logic [INSTR_WIDTH-1:0]   decode_instruction_o,
  output logic [XLEN-1:0]          decode_PC_o,
  output logic                     decode_NLP_BTB_hit_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int unsigned PW      = ptr_width(DEPTH);
  localparam int unsigned AW      = PW - 1;
  localparam int unsigned EW      = entry_width(INSTR_WIDTH, XLEN);
  localparam int unsigned PC_LSB  = pc_lsb(INSTR_WIDTH);
  localparam int unsigned HIT_BIT = hit_bit(INSTR_WIDTH, XLEN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full, ready;
  logic          stored_valid, push, pop;
  logic          bypass_active, bypass_taken;
  logic [EW-1:0] wr_entry, rd_entry;

  // Status flags, handshakes and next-pointer computation.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    ready        = !full && !flush_i && !reset;
    stored_valid = !empty && !flush_i;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    bypass_active = empty && fetch_response_valid_i && !flush_i && !reset;
    bypass_taken  = bypass_active && decode_ready_i;
`else
    bypass_active = 1'b0;
    bypass_taken  = 1'b0;
`endif
    // A bypassed entry consumed this cycle never touches storage.
    push     = fetch_response_valid_i && ready && !bypass_taken;
    pop      = stored_valid && decode_ready_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; wrap modulo 2*DEPTH falls out of the PW-bit adders.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Pack the incoming entry for storage.
  always_comb begin
    wr_entry = {fetch_NLP_BTB_hit_i, fetch_response_PC_i, fetch_response_instruction_i};
  end

  fetch_decode_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // Decode-side outputs: stored head, else fall-through input, else NOP.
  always_comb begin
    fetch_response_ready_o = ready;
    decode_valid_o         = stored_valid || bypass_active;
    occupancy_o            = wr_ptr_q - rd_ptr_q;
    decode_instruction_o   = INSTR_WIDTH'(NOP_INSTRUCTION);
    decode_PC_o            = '0;
    decode_NLP_BTB_hit_o   = 1'b0;
    if (stored_valid) begin
      decode_instruction_o = rd_entry[INSTR_WIDTH-1:0];
      decode_PC_o          = rd_entry[PC_LSB +: XLEN];
      decode_NLP_BTB_hit_o = rd_entry[HIT_BIT];
    end else if (bypass_active) begin
      decode_instruction_o = fetch_response_instruction_i;
      decode_PC_o          = fetch_response_PC_i;
      decode_NLP_BTB_hit_o = fetch_NLP_BTB_hit_i;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 32;

  typedef struct {
    logic [IW-1:0]   instr;
    logic [XLEN-1:0] pc;
    logic            hit;
  } ent_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            fvalid = 1'b0;
  logic            fready;
  logic [IW-1:0]   finstr = '0;
  logic [XLEN-1:0] fpc = '0;
  logic            fhit = 1'b0;
  logic            dvalid;
  logic            dready = 1'b0;
  logic [IW-1:0]   dinstr;
  logic [XLEN-1:0] dpc;
  logic            dhit;
  logic [$clog2(DEPTH):0] occ;

  int checks = 0;
  int errors = 0;
  ent_t sb[$];

  fetch_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .INSTR_WIDTH(IW)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .flush_i                      (flush),
    .fetch_response_valid_i       (fvalid),
    .fetch_response_ready_o       (fready),
    .fetch_response_instruction_i (finstr),
    .fetch_response_PC_i          (fpc),
    .fetch_NLP_BTB_hit_i          (fhit),
    .decode_valid_o               (dvalid),
    .decode_ready_i               (dready),
    .decode_instruction_o         (dinstr),
    .decode_PC_o                  (dpc),
    .decode_NLP_BTB_hit_o         (dhit),
    .occupancy_o                  (occ)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model
  // by the handshakes that will happen on the coming rising edge.
  always @(negedge clock) begin
    ent_t exp_e;
    bit   exp_ready, exp_valid, byp;
    if (reset) sb.delete();
    exp_ready = (sb.size() < DEPTH) && !flush && !reset;
    byp = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && fvalid && !flush && !reset;
`endif
    exp_valid = ((sb.size() > 0) && !flush) || byp;
    if ((sb.size() > 0) && !flush) exp_e = sb[0];
    else if (byp) exp_e = '{instr: finstr, pc: fpc, hit: fhit};
    else exp_e = '{instr: 32'h00000013, pc: '0, hit: 1'b0};

    check("ready", 64'(fready), 64'(exp_ready));
    check("valid", 64'(dvalid), 64'(exp_valid));
    check("occupancy", 64'(occ), 64'(sb.size()));
    check("instr", 64'(dinstr), 64'(exp_e.instr));
    check("pc", dpc, exp_e.pc);
    check("btb_hit", 64'(dhit), 64'(exp_e.hit));

    if (!reset) begin
      if (flush) sb.delete();
      else if (!(byp && dready)) begin
        if ((sb.size() > 0) && dready) void'(sb.pop_front());
        if (exp_ready && fvalid) sb.push_back('{instr: finstr, pc: fpc, hit: fhit});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present one entry and hold it until the queue takes it (bounded).
  task automatic push_hold(input logic [IW-1:0] instr, input logic [XLEN-1:0] pc, input logic hit);
    bit acc;
    int n;
    fvalid = 1'b1; finstr = instr; fpc = pc; fhit = hit;
    acc = 1'b0;
    for (n = 0; n < 50 && !acc; n++) begin
      @(negedge clock);
      acc = fready;
      cyc();
    end
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout pc=%0h: got no ready expected ready within 50 cycles", pc);
    end
    fvalid = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // Single NOP push with decode ready.
    dready = 1'b1;
    push_hold(32'h00000013, '0, 1'b0);
    repeat (2) cyc();

    // Fill with decode stalled, hold a fifth, then drain.
    dready = 1'b0;
    for (int i = 0; i < 4; i++) push_hold($urandom, XLEN'(4 * i), 1'(i));
    fvalid = 1'b1; finstr = $urandom; fpc = 64'd16; fhit = 1'b1;
    repeat (3) cyc();
    dready = 1'b1;
    push_hold(finstr, 64'd16, 1'b1);
    repeat (6) cyc();

    // Sustained streaming across pointer wrap.
    pc = 64'h1000;
    fvalid = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      finstr = $urandom; fpc = pc; fhit = 1'($urandom);
      pc += 4;
      cyc();
    end
    fvalid = 1'b0;
    repeat (3) cyc();

    // Flush with three stored and a concurrent push.
    dready = 1'b0;
    for (int i = 0; i < 3; i++) push_hold($urandom, 64'h2000 + 64'(4 * i), 1'b0);
    fvalid = 1'b1; finstr = $urandom; fpc = 64'h2ffc; flush = 1'b1;
    cyc();
    flush = 1'b0; fvalid = 1'b0;
    cyc();
    push_hold($urandom, 64'h3000, 1'b1);
    dready = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset with two entries stored.
    dready = 1'b0;
    push_hold($urandom, 64'h4000, 1'b0);
    push_hold($urandom, 64'h4004, 1'b1);
    cyc();
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(dvalid), 64'd0);
    check("async_rst_occ", 64'(occ), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    dready = 1'b1;
    push_hold($urandom, 64'h5000, 1'b1);
    repeat (3) cyc();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      fvalid = 1'($urandom);
      dready = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      finstr = $urandom;
      fpc    = {$urandom, $urandom};
      fhit   = 1'($urandom);
      cyc();
    end
    fvalid = 1'b0; flush = 1'b0; dready = 1'b1;
    repeat (6) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
